// File: rtl/aes_inv_mix_columns_seq_if.sv
// Block-level handshake bundle for the inverse MixColumns sequencer.
// The slave modport is the sequencer side; the master modport is the upstream/downstream side.
interface aes_inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_bypass,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    output in_bypass,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );
endinterface

// File: rtl/aes_inv_mix_columns_seq.sv
// Column-serial AES inverse MixColumns: one 32-bit column per cycle through a single
// shared column function, with a per-block bypass for the final decryption round.
module aes_inv_mix_columns_seq (
  input  logic                            clk,
  input  logic                            rst,
  aes_inv_mix_columns_seq_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Row 0 is the MSB byte; each output row rotates the 0E/0B/0D/09 coefficient set.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    {a0, a1, a2, a3} = col;
    o0 = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
    o1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
    o2 = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
    o3 = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    return {o0, o1, o2, o3};
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_col;
  logic         r_bypass;
  logic [127:0] r_src;
  logic [127:0] r_out;

  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_busy;
  logic         w_accept;
  logic         w_col_we;
  logic [6:0]   w_col_lsb;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;

  // Column c lives at bits [127-32c -: 32], i.e. LSB index (3-c)*32 == {~c, 5'b0}.
  assign w_col_lsb = {~r_col, 5'd0};
  assign w_col_in  = r_src[w_col_lsb +: 32];

  // The one shared column-function instance, fed by the column counter.
  assign w_col_out = inv_mix_column(w_col_in);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: each combinational output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_col_we    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_busy = 1'b1;
        // Bypass blocks spend exactly one cycle here, giving the 1-cycle bypass latency.
        if (r_bypass) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_col_we = 1'b1;
          if (r_col == 2'd3) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the 128-bit holding registers are reset too, so an aborted block leaves no residue on out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col    <= 2'd0;
      r_bypass <= 1'b0;
      r_src    <= '0;
      r_out    <= '0;
    end else begin
      if (w_accept) begin
        r_src    <= bus.in_data;
        r_bypass <= bus.in_bypass;
        r_col    <= 2'd0;
        if (bus.in_bypass) begin
          r_out <= bus.in_data;
        end
      end
      if (w_col_we) begin
        r_out[w_col_lsb +: 32] <= w_col_out;
        r_col                  <= r_col + 2'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_data  = r_out;

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Directed self-checking bench for aes_inv_mix_columns_seq using known AES column vectors.
module tb_aes_inv_mix_columns_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  aes_inv_mix_columns_seq_if bus();

  aes_inv_mix_columns_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] N1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] N1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] B1_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] N2_IN  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
  localparam logic [127:0] N2_OUT = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [127:0] B2_IN  = 128'h01234567_89abcdef_fedcba98_76543210;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a block and return #1 after the edge that accepted it.
  task automatic drive_accept(input logic [127:0] d, input logic byp);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_bypass = byp;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_output();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int lat;
    drive_accept(N1_IN, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL normal_busy: busy=%0b in_ready=%0b want 1/0", bus.busy, bus.in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL normal_latency: got %0d want 4", lat); end
    checks++;
    if (bus.out_data !== N1_OUT) begin failures++; $display("FAIL normal_data: got %h want %h", bus.out_data, N1_OUT); end
    release_output();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL normal_release: in_ready=%0b out_valid=%0b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_bypass();
    int lat;
    drive_accept(B1_IN, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL bypass_latency: got %0d want 1", lat); end
    checks++;
    if (bus.out_data !== B1_IN) begin failures++; $display("FAIL bypass_data: got %h want %h", bus.out_data, B1_IN); end
    release_output();
  endtask

  task automatic test_backpressure();
    int lat;
    drive_accept(N1_IN, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== N1_OUT) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%0b in_ready=%0b data=%h want 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.out_data, N1_OUT);
      end
      bus.in_valid  = (i == 3);
      bus.in_data   = {4{32'hffff_ffff}};
      bus.in_bypass = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    release_output();
    checks++;
    if (bus.out_data !== N1_OUT) begin failures++; $display("FAIL backpressure_data_hold: got %h want %h", bus.out_data, N1_OUT); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL backpressure_ignored: out_valid=%0b busy=%0b want 0/0", bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    drive_accept(N1_IN, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 128'h0) begin
      failures++;
      $display("FAIL midreset_async: in_ready=%0b out_valid=%0b busy=%0b data=%h want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_accept(N2_IN, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL midreset_latency: got %0d want 4", lat); end
    checks++;
    if (bus.out_data !== N2_OUT) begin failures++; $display("FAIL midreset_data: got %h want %h", bus.out_data, N2_OUT); end
    release_output();
  endtask

  task automatic test_back_to_back();
    logic [127:0] vec [4];
    logic         byp [4];
    logic [127:0] exp [4];
    int           acc_cyc [4];
    int           idx;
    int           out_idx;
    int           cyc;
    vec = '{N1_IN, B1_IN, N2_IN, B2_IN};
    byp = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp = '{N1_OUT, B1_IN, N2_OUT, B2_IN};
    idx = 0; out_idx = 0; cyc = 0;
    bus.out_ready = 1'b1;
    while (out_idx < 4 && cyc < 100) begin
      if (bus.in_ready && idx < 4) begin
        bus.in_valid  = 1'b1;
        bus.in_data   = vec[idx];
        bus.in_bypass = byp[idx];
        acc_cyc[idx]  = cyc;
        idx++;
      end else begin
        bus.in_valid  = (idx < 4);
        bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
        bus.in_bypass = 1'($urandom_range(0, 1));
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== exp[out_idx]) begin
          failures++; $display("FAIL b2b_data[%0d]: got %h want %h", out_idx, bus.out_data, exp[out_idx]);
        end
        out_idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (out_idx != 4) begin failures++; $display("FAIL b2b_timeout: got %0d outputs want 4", out_idx); end
    else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 6) begin failures++; $display("FAIL b2b_period_normal1: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
      checks++;
      if (acc_cyc[2] - acc_cyc[1] != 3) begin failures++; $display("FAIL b2b_period_bypass1: got %0d want 3", acc_cyc[2] - acc_cyc[1]); end
      checks++;
      if (acc_cyc[3] - acc_cyc[2] != 6) begin failures++; $display("FAIL b2b_period_normal2: got %0d want 6", acc_cyc[3] - acc_cyc[2]); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_normal();
    test_bypass();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
